micro_seq_control_unit: RTL and testbench
=========================================

Name: micro_seq_control_unit

Overview:
Parametrised successor to the pipeline's ID-stage control unit. Decodes the 6-bit opcode into execute, memory, write-back and branch controls. Multi-cycle SWP-class instructions run as UOP_COUNT micro-ops, sequenced by an explicit FSM. The FSM freezes IF/ID while it runs and honours a hazard-unit stall.

Parameters:
OPCODE_W, 6, opcode width
CMD_W, 4, exec_cmd width
UOP_COUNT, 2, micro-ops per multi-cycle instruction (2..8)
SEQ_OPCODE, 6'b111111, opcode of the multi-cycle instruction
SEQ_CMD_BASE, 4'b1100, exec_cmd of micro-op 0; micro-op k issues SEQ_CMD_BASE+k

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  opcode of the instruction in ID
instr_valid  in  1  ID holds a real instruction; 0 = bubble
stall  in  1  hazard stall; sequencer holds its position
freeze  out  1  hold PC and IF/ID register
uop_idx  out  3  current micro-op index
swp_sel  out  UOP_COUNT  one-hot micro-op select to the register-file port mux
exec_cmd  out  CMD_W  ALU command
mem_r_en  out  1  memory read
mem_w_en  out  1  memory write
wb_en  out  1  register write-back
is_imm  out  1  second operand is the immediate
branch_type  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP
single_src  out  1  only rs1 is read
illegal  out  1  undefined opcode (see Optional Feature)

Behaviour:
- Decode is combinational from opcode, FSM state and uop_idx.
- Every control output defaults to 0. instr_valid=0 forces all controls to 0.
- Opcode table (controls not listed are 0):
  - 000000 NOP: cmd 0000.
  - ADD 000001: 0000, wb.
  - SUB 000011: 0010, wb.
  - AND 000101: 0100, wb.
  - OR 000110: 0101, wb.
  - NOR 000111: 0110, wb.
  - XOR 001000: 0111, wb.
  - SLA 001001 and SLL 001010: 1000, wb.
  - SRA 001011: 1001, wb.
  - SRL 001100: 1010, wb.
  - ADDI 100000: 0000, imm, wb, single.
  - SUBI 100001: 0010, imm, wb, single.
  - LD 100100: 0000, imm, mem_r, wb, single.
  - ST 100101: 0000, imm, mem_w.
  - BEZ 101000: imm, br 01, single.
  - BNE 101001: imm, br 10.
  - JMP 101010: imm, br 11, single.
- FSM states: IDLE, SEQ. Registered state and uop_idx; reset to IDLE and 0.
- IDLE with instr_valid=1 and opcode=SEQ_OPCODE: issue micro-op 0.
  - Issue means: wb_en=1, exec_cmd=SEQ_CMD_BASE, swp_sel=1, freeze=1.
  - If stall=0: next state SEQ, uop_idx=1.
- SEQ at index k: wb_en=1, exec_cmd=SEQ_CMD_BASE+k, swp_sel=1<<k.
  - freeze=1 for k<UOP_COUNT-1; freeze=0 on the last micro-op.
  - If stall=0: k<UOP_COUNT-1 advances to k+1. Last micro-op returns to IDLE with uop_idx=0.
- stall=1 in any state: state and uop_idx hold; outputs repeat the same micro-op.
- In SEQ, opcode and instr_valid are ignored, since IF/ID is frozen.
- Back-to-back SEQ_OPCODE: the last micro-op returns to IDLE. The next instruction then starts at micro-op 0 with no idle cycle.
- exec_cmd arithmetic is modulo 2^CMD_W.
- Reset asserted mid-sequence: immediate return to IDLE, uop_idx=0, all outputs 0 while rst_n=0. The interrupted instruction is discarded.
- Latency: single-cycle ops take 0 cycles (combinational). SEQ_OPCODE occupies exactly UOP_COUNT unstalled cycles.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: a valid opcode outside the table and not SEQ_OPCODE drives illegal=1, with all other controls 0, for that cycle.
- Undefined: illegal is tied 0 and unknown opcodes decode as NOP.

Test Plan:
- Default params, opcode 111111 valid, no stall:
  - cycle 0: cmd 1100, swp_sel 01, freeze 1, wb 1.
  - cycle 1: cmd 1101, swp_sel 10, freeze 0, wb 1.
  - cycle 2: IDLE.
- UOP_COUNT=4, SEQ opcode:
  - cmds 1100, 1101, 1110, 1111.
  - swp_sel 0001, 0010, 0100, 1000.
  - freeze 1,1,1,0.
- Default params, SEQ with stall=1 in cycle 1 for 3 cycles: cmd 1101 and swp_sel 10 hold for 4 cycles, then IDLE.
- Walk all table opcodes, including LD 100100 (cmd 0000, mem_r 1, wb 1, is_imm 1, single 1) and BNE 101001 (branch_type 10) -> outputs match the table exactly.
- rst_n low during micro-op 1 of a 4-op sequence -> outputs 0 immediately. After release, opcode 000001 gives cmd 0000, wb 1.
- ILLEGAL_TRAP_EN defined, opcode 010101 valid -> illegal 1, wb 0. Macro undefined -> illegal 0, NOP controls.

Source files
------------

// File: rtl/micro_seq_control_unit.sv
// ID-stage control unit: opcode decode plus a micro-op sequencer for the multi-cycle SWP-class opcode.
// Optional feature macro: ILLEGAL_TRAP_EN (flags undefined opcodes on the illegal output).
module micro_seq_control_unit #(
   parameter int unsigned         OPCODE_W     = 6,
   parameter int unsigned         CMD_W        = 4,
   parameter int unsigned         UOP_COUNT    = 2,
   parameter logic [OPCODE_W-1:0] SEQ_OPCODE   = 6'b111111,
   parameter logic [CMD_W-1:0]    SEQ_CMD_BASE = 4'b1100
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic                 instr_valid,
   input  logic                 stall,
   output logic                 freeze,
   output logic [2:0]           uop_idx,
   output logic [UOP_COUNT-1:0] swp_sel,
   output logic [CMD_W-1:0]     exec_cmd,
   output logic                 mem_r_en,
   output logic                 mem_w_en,
   output logic                 wb_en,
   output logic                 is_imm,
   output logic [1:0]           branch_type,
   output logic                 single_src,
   output logic                 illegal
);

   typedef enum logic {IDLE, SEQ} state_t;

   state_t     state;
   logic [2:0] idx;
   logic       seq_hit;
   logic       seq_active;
   logic       last_uop;

   // Micro-op 0 issues straight out of IDLE, so the sequence is active on the opcode match itself.
   assign seq_hit    = instr_valid && (opcode == SEQ_OPCODE);
   assign seq_active = (state == SEQ) || seq_hit;
   assign last_uop   = (idx == 3'(UOP_COUNT - 1));
   assign uop_idx    = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else if (!stall && seq_active) begin
         if (last_uop) begin
            state <= IDLE;
            idx   <= '0;
         end else begin
            state <= SEQ;
            idx   <= idx + 3'd1;
         end
      end
   end

   always_comb begin
      freeze      = 1'b0;
      swp_sel     = '0;
      exec_cmd    = '0;
      mem_r_en    = 1'b0;
      mem_w_en    = 1'b0;
      wb_en       = 1'b0;
      is_imm      = 1'b0;
      branch_type = 2'b00;
      single_src  = 1'b0;
      illegal     = 1'b0;
      // Controls are gated by rst_n so nothing leaks out while reset is held.
      if (rst_n) begin
         if (seq_active) begin
            wb_en    = 1'b1;
            exec_cmd = SEQ_CMD_BASE + CMD_W'(idx);
            swp_sel  = UOP_COUNT'(1) << idx;
            freeze   = !last_uop;
         end else if (instr_valid) begin
            case (opcode)
               6'b000001: wb_en = 1'b1;
               6'b000011: begin exec_cmd = 4'b0010; wb_en = 1'b1; end
               6'b000101: begin exec_cmd = 4'b0100; wb_en = 1'b1; end
               6'b000110: begin exec_cmd = 4'b0101; wb_en = 1'b1; end
               6'b000111: begin exec_cmd = 4'b0110; wb_en = 1'b1; end
               6'b001000: begin exec_cmd = 4'b0111; wb_en = 1'b1; end
               6'b001001,
               6'b001010: begin exec_cmd = 4'b1000; wb_en = 1'b1; end
               6'b001011: begin exec_cmd = 4'b1001; wb_en = 1'b1; end
               6'b001100: begin exec_cmd = 4'b1010; wb_en = 1'b1; end
               6'b100000: begin is_imm = 1'b1; wb_en = 1'b1; single_src = 1'b1; end
               6'b100001: begin
                  exec_cmd   = 4'b0010;
                  is_imm     = 1'b1;
                  wb_en      = 1'b1;
                  single_src = 1'b1;
               end
               6'b100100: begin
                  is_imm     = 1'b1;
                  mem_r_en   = 1'b1;
                  wb_en      = 1'b1;
                  single_src = 1'b1;
               end
               6'b100101: begin is_imm = 1'b1; mem_w_en = 1'b1; end
               6'b101000: begin is_imm = 1'b1; branch_type = 2'b01; single_src = 1'b1; end
               6'b101001: begin is_imm = 1'b1; branch_type = 2'b10; end
               6'b101010: begin is_imm = 1'b1; branch_type = 2'b11; single_src = 1'b1; end
               6'b000000: exec_cmd = 4'b0000;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  illegal = 1'b1;
`else
                  illegal = 1'b0;
`endif
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_micro_seq_control_unit.sv
// Bench for micro_seq_control_unit: opcode table walk, hand-written sequencer cases and random traffic
// against a queue-based reference, on a UOP_COUNT=2 and a UOP_COUNT=4 instance sharing one stimulus.
module tb_micro_seq_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       instr_valid;
   logic       stall;

   logic       a_freeze, a_mr, a_mw, a_wb, a_imm, a_single, a_ill;
   logic [2:0] a_idx;
   logic [1:0] a_swp, a_br;
   logic [3:0] a_cmd;
   logic       b_freeze, b_mr, b_mw, b_wb, b_imm, b_single, b_ill;
   logic [2:0] b_idx;
   logic [3:0] b_swp;
   logic [1:0] b_br;
   logic [3:0] b_cmd;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0] op;
      logic [3:0] cmd;
      logic       mr;
      logic       mw;
      logic       wb;
      logic       imm;
      logic [1:0] br;
      logic       single;
   } dec_t;
   dec_t tbl[18];

   int pend[2][$];

   always #5 clk = ~clk;

   micro_seq_control_unit #(.UOP_COUNT(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid), .stall(stall),
      .freeze(a_freeze), .uop_idx(a_idx), .swp_sel(a_swp), .exec_cmd(a_cmd),
      .mem_r_en(a_mr), .mem_w_en(a_mw), .wb_en(a_wb), .is_imm(a_imm),
      .branch_type(a_br), .single_src(a_single), .illegal(a_ill));

   micro_seq_control_unit #(.UOP_COUNT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid), .stall(stall),
      .freeze(b_freeze), .uop_idx(b_idx), .swp_sel(b_swp), .exec_cmd(b_cmd),
      .mem_r_en(b_mr), .mem_w_en(b_mw), .wb_en(b_wb), .is_imm(b_imm),
      .branch_type(b_br), .single_src(b_single), .illegal(b_ill));

   function automatic logic [31:0] pack(input logic fr, input logic [2:0] idx, input logic [7:0] swp,
                                        input logic [3:0] cmd, input logic mr, input logic mw,
                                        input logic wb, input logic imm, input logic [1:0] br,
                                        input logic sg, input logic il);
      return {8'h00, fr, idx, swp, cmd, mr, mw, wb, imm, br, sg, il};
   endfunction

   logic [31:0] got_a, got_b;
   always_comb got_a = pack(a_freeze, a_idx, {6'b0, a_swp}, a_cmd, a_mr, a_mw, a_wb, a_imm, a_br, a_single, a_ill);
   always_comb got_b = pack(b_freeze, b_idx, {4'b0, b_swp}, b_cmd, b_mr, b_mw, b_wb, b_imm, b_br, b_single, b_ill);

   // k is the micro-op in flight from the pending queue, or -1 when no sequence is in progress.
   function automatic logic [31:0] exp_ctrl(input int n, input int k, input logic [5:0] op,
                                            input logic v, input logic rst);
      int kk = k;
      if (!rst) return 32'h0;
      if (kk < 0 && v && op == 6'h3F) kk = 0;
      if (kk >= 0)
         return pack(kk != n - 1, 3'(kk), 8'(1 << kk), 4'((12 + kk) % 16),
                     1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      if (!v) return 32'h0;
      for (int i = 0; i < 18; i++)
         if (tbl[i].op == op)
            return pack(1'b0, 3'd0, 8'h00, tbl[i].cmd, tbl[i].mr, tbl[i].mw, tbl[i].wb,
                        tbl[i].imm, tbl[i].br, tbl[i].single, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      return pack(1'b0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
`else
      return 32'h0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int front(input int i);
      return (pend[i].size() > 0) ? pend[i][0] : -1;
   endfunction

   task automatic cycle(input logic [5:0] op, input logic v, input logic st);
      @(negedge clk);
      opcode = op; instr_valid = v; stall = st;
      #1;
      check("ctrl_u2", got_a, exp_ctrl(2, front(0), op, v, rst_n));
      check("ctrl_u4", got_b, exp_ctrl(4, front(1), op, v, rst_n));
      if (rst_n && !st)
         for (int i = 0; i < 2; i++) begin
            if (pend[i].size() > 0) void'(pend[i].pop_front());
            else if (v && op == 6'h3F)
               for (int k = 1; k < (i == 0 ? 2 : 4); k++) pend[i].push_back(k);
         end
   endtask

   initial begin
      tbl[0]  = '{6'b000000, 4'b0000, 0, 0, 0, 0, 2'b00, 0};
      tbl[1]  = '{6'b000001, 4'b0000, 0, 0, 1, 0, 2'b00, 0};
      tbl[2]  = '{6'b000011, 4'b0010, 0, 0, 1, 0, 2'b00, 0};
      tbl[3]  = '{6'b000101, 4'b0100, 0, 0, 1, 0, 2'b00, 0};
      tbl[4]  = '{6'b000110, 4'b0101, 0, 0, 1, 0, 2'b00, 0};
      tbl[5]  = '{6'b000111, 4'b0110, 0, 0, 1, 0, 2'b00, 0};
      tbl[6]  = '{6'b001000, 4'b0111, 0, 0, 1, 0, 2'b00, 0};
      tbl[7]  = '{6'b001001, 4'b1000, 0, 0, 1, 0, 2'b00, 0};
      tbl[8]  = '{6'b001010, 4'b1000, 0, 0, 1, 0, 2'b00, 0};
      tbl[9]  = '{6'b001011, 4'b1001, 0, 0, 1, 0, 2'b00, 0};
      tbl[10] = '{6'b001100, 4'b1010, 0, 0, 1, 0, 2'b00, 0};
      tbl[11] = '{6'b100000, 4'b0000, 0, 0, 1, 1, 2'b00, 1};
      tbl[12] = '{6'b100001, 4'b0010, 0, 0, 1, 1, 2'b00, 1};
      tbl[13] = '{6'b100100, 4'b0000, 1, 0, 1, 1, 2'b00, 1};
      tbl[14] = '{6'b100101, 4'b0000, 0, 1, 0, 1, 2'b00, 0};
      tbl[15] = '{6'b101000, 4'b0000, 0, 0, 0, 1, 2'b01, 1};
      tbl[16] = '{6'b101001, 4'b0000, 0, 0, 0, 1, 2'b10, 0};
      tbl[17] = '{6'b101010, 4'b0000, 0, 0, 0, 1, 2'b11, 1};

      rst_n = 1'b0; opcode = 6'b000001; instr_valid = 1'b1; stall = 1'b0;
      #3;
      check("reset_u2", got_a, 32'h0);
      check("reset_u4", got_b, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table walk, valid and as bubbles.
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].op, 1'b1, 1'b0);
         check("table", got_a, pack(1'b0, 3'd0, 8'h00, tbl[i].cmd, tbl[i].mr, tbl[i].mw, tbl[i].wb,
                                    tbl[i].imm, tbl[i].br, tbl[i].single, 1'b0));
         cycle(tbl[i].op, 1'b0, 1'b0);
         check("bubble", got_a, 32'h0);
      end

      // Default SEQ, unstalled; then drain the 4-op instance.
      cycle(6'h3F, 1'b1, 1'b0);
      check("seq0_u2", {a_freeze, a_wb, a_swp, a_cmd}, {24'h0, 1'b1, 1'b1, 2'b01, 4'b1100});
      cycle(6'h00, 1'b0, 1'b0);
      check("seq1_u2", {a_freeze, a_wb, a_swp, a_cmd}, {24'h0, 1'b0, 1'b1, 2'b10, 4'b1101});
      cycle(6'h00, 1'b0, 1'b0);
      check("seq_idle_u2", got_a, 32'h0);
      cycle(6'h00, 1'b0, 1'b0);
      cycle(6'h00, 1'b0, 1'b0);
      check("seq_idle_u4", got_b, 32'h0);

      // UOP_COUNT=4 sequence, explicit values.
      for (int k = 0; k < 4; k++) begin
         cycle(k == 0 ? 6'h3F : 6'h00, k == 0, 1'b0);
         check("seq_u4", {b_freeze, b_swp, b_cmd},
               {23'h0, 1'b0, 4'(k != 3 ? 1 : 0), 4'(1 << k), 4'(12 + k)});
      end
      cycle(6'h00, 1'b0, 1'b0);
      check("seq_u4_done", got_b, 32'h0);

      // Stall during micro-op 1 for 3 cycles.
      cycle(6'h3F, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) begin
         cycle(6'h00, 1'b0, c < 3);
         check("stall_hold", {a_swp, a_cmd}, {26'h0, 2'b10, 4'b1101});
      end
      cycle(6'h00, 1'b0, 1'b0);
      check("stall_idle", got_a, 32'h0);
      cycle(6'h00, 1'b0, 1'b0);
      cycle(6'h00, 1'b0, 1'b0);

      // Back-to-back sequence instructions on the 2-op instance.
      cycle(6'h3F, 1'b1, 1'b0);
      cycle(6'h3F, 1'b1, 1'b0);
      cycle(6'h3F, 1'b1, 1'b0);
      check("b2b_restart", {a_idx, a_cmd}, {25'h0, 3'd0, 4'b1100});
      cycle(6'h00, 1'b0, 1'b0);
      cycle(6'h00, 1'b0, 1'b0);
      cycle(6'h00, 1'b0, 1'b0);

      // Reset during micro-op 1 of the 4-op sequence.
      cycle(6'h3F, 1'b1, 1'b0);
      cycle(6'h00, 1'b0, 1'b0);
      rst_n = 1'b0; opcode = 6'b000001; instr_valid = 1'b1;
      #1;
      check("rst_mid_u4", got_b, 32'h0);
      check("rst_mid_u2", got_a, 32'h0);
      pend[0].delete(); pend[1].delete();
      @(negedge clk); #1;
      check("rst_hold_u4", got_b, 32'h0);
      rst_n = 1'b1;
      cycle(6'b000001, 1'b1, 1'b0);
      check("post_rst_add", {b_idx, b_wb, b_cmd}, {24'h0, 3'd0, 1'b1, 4'b0000});

      // Undefined opcode.
      cycle(6'b010101, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      check("illegal", {a_ill, a_wb}, {30'h0, 2'b10});
`else
      check("illegal", got_a, 32'h0);
`endif

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         logic [5:0] op;
         int sel = int'($urandom_range(0, 3));
         if (sel == 0) op = 6'h3F;
         else if (sel == 3) op = 6'($urandom);
         else op = tbl[$urandom_range(0, 17)].op;
         cycle(op, ($urandom % 4) != 0, ($urandom % 4) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
